// File: rtl/reg_bus_cmd_bridge.sv
// Byte-stream command bridge: parses framed write/read packets from a byte source,
// drives the simple register bus as initiator and returns an ack byte or read data.
module reg_bus_cmd_bridge #(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        sysclk_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        wr_ena_o,
    output logic [3:0]  wr_addr_o,
    output logic [3:0]  wr_byte_sel_o,
    output logic [31:0] wr_data_o,
    output logic        rd_ena_o,
    output logic [3:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        busy_o,
    output logic        err_timeout_o
);

    // state   | meaning
    // S_IDLE  | waiting for an opcode byte
    // S_HDR   | waiting for the header byte (byte_sel, addr)
    // S_WDATA | collecting 4 write data bytes, LS byte first
    // S_WRITE | one-cycle wr_ena_o strobe
    // S_READ  | one-cycle rd_ena_o strobe
    // S_RWAIT | waiting RD_LATENCY cycles for rd_data_i
    // S_RESP  | streaming the response buffer out, LS byte first
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_RESP
    } state_t;

    localparam int unsigned TCW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Down-counter is loaded with limit-1 so the abort lands exactly TIMEOUT_CYCLES after the last byte.
    localparam logic [TCW-1:0] TO_LOAD = (TIMEOUT_CYCLES == 0) ? '0 : TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]     RL_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [7:0]     OP_WR   = 8'h57;
    localparam logic [7:0]     OP_RD   = 8'h52;
    localparam logic [7:0]     RSP_ACK = 8'h4B;
    localparam logic [7:0]     RSP_BAD = 8'h3F;

    state_t          state_q, state_d;
    logic            is_wr_q, is_wr_d;
    logic [3:0]      addr_q, addr_d;
    logic [3:0]      sel_q, sel_d;
    logic [23:0]     wbuf_q, wbuf_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic [31:0]     resp_q, resp_d;
    logic [2:0]      rlen_q, rlen_d;
    logic [3:0]      wr_addr_q, wr_addr_d;
    logic [3:0]      wr_sel_q, wr_sel_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic [3:0]      rd_addr_q, rd_addr_d;
    logic            err_q, err_d;

    logic            rx_fire;
    logic            tx_fire;
    logic            timeout_hit;

    assign rx_ready_o  = ~reset_i & ((state_q == S_IDLE) | (state_q == S_HDR) | (state_q == S_WDATA));
    assign rx_fire     = rx_valid_i & rx_ready_o;
    assign tx_valid_o  = (state_q == S_RESP);
    assign tx_fire     = tx_valid_o & tx_ready_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == '0);

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wbuf_d    = wbuf_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        rcnt_d    = rcnt_q;
        resp_d    = resp_q;
        rlen_d    = rlen_q;
        wr_addr_d = wr_addr_q;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data_i == OP_WR || rx_data_i == OP_RD) begin
                        is_wr_d = (rx_data_i == OP_WR);
                        tcnt_d  = TO_LOAD;
                        state_d = S_HDR;
                    end else begin
                        resp_d  = {24'h0, RSP_BAD};
                        rlen_d  = 3'd1;
                        state_d = S_RESP;
                    end
                end
            end
            S_HDR: begin
                if (rx_fire) begin
                    sel_d  = rx_data_i[7:4];
                    addr_d = rx_data_i[3:0];
                    tcnt_d = TO_LOAD;
                    if (is_wr_q) begin
                        bcnt_d  = 2'd0;
                        state_d = S_WDATA;
                    end else begin
                        rd_addr_d = rx_data_i[3:0];
                        state_d   = S_READ;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (tcnt_q != '0) begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            S_WDATA: begin
                if (rx_fire) begin
                    tcnt_d = TO_LOAD;
                    if (bcnt_q == 2'd3) begin
                        wr_data_d = {rx_data_i, wbuf_q};
                        wr_addr_d = addr_q;
                        wr_sel_d  = sel_q;
                        state_d   = S_WRITE;
                    end else begin
                        wbuf_d[{bcnt_q, 3'b000} +: 8] = rx_data_i;
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (tcnt_q != '0) begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            S_WRITE: begin
                resp_d  = {24'h0, RSP_ACK};
                rlen_d  = 3'd1;
                state_d = S_RESP;
            end
            S_READ: begin
                rcnt_d  = RL_LOAD;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (rcnt_q == 4'd0) begin
                    resp_d  = rd_data_i;
                    rlen_d  = 3'd4;
                    state_d = S_RESP;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    resp_d = {8'h00, resp_q[31:8]};
                    rlen_d = rlen_q - 3'd1;
                    if (rlen_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            wbuf_q    <= '0;
            bcnt_q    <= '0;
            tcnt_q    <= '0;
            rcnt_q    <= '0;
            resp_q    <= '0;
            rlen_q    <= '0;
            wr_addr_q <= '0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wbuf_q    <= wbuf_d;
            bcnt_q    <= bcnt_d;
            tcnt_q    <= tcnt_d;
            rcnt_q    <= rcnt_d;
            resp_q    <= resp_d;
            rlen_q    <= rlen_d;
            wr_addr_q <= wr_addr_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
        end
    end

    assign tx_data_o     = tx_valid_o ? resp_q[7:0] : 8'h00;
    assign wr_ena_o      = (state_q == S_WRITE);
    assign rd_ena_o      = (state_q == S_READ);
    assign wr_addr_o     = wr_addr_q;
    assign wr_byte_sel_o = wr_sel_q;
    assign wr_data_o     = wr_data_q;
    assign rd_addr_o     = rd_addr_q;
    assign busy_o        = (state_q != S_IDLE);
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_reg_bus_cmd_bridge.sv
// Directed bench for reg_bus_cmd_bridge: packet vector table plus hand sequences
// for timeout, byte-wins-at-limit and mid-packet reset.
module tb_reg_bus_cmd_bridge;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        wr_ena_o;
    logic [3:0]  wr_addr_o;
    logic [3:0]  wr_byte_sel_o;
    logic [31:0] wr_data_o;
    logic        rd_ena_o;
    logic [3:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic        busy_o;
    logic        err_timeout_o;

    reg_bus_cmd_bridge #(.RD_LATENCY(1), .TIMEOUT_CYCLES(8)) dut (
        .sysclk_i(clk), .reset_i(reset_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .wr_ena_o(wr_ena_o), .wr_addr_o(wr_addr_o), .wr_byte_sel_o(wr_byte_sel_o),
        .wr_data_o(wr_data_o), .rd_ena_o(rd_ena_o), .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i), .busy_o(busy_o), .err_timeout_o(err_timeout_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          nb;
        logic [47:0] by;
        int          stall;
        logic [31:0] rd_val;
        int          exp_wr;
        int          exp_rd;
        logic [3:0]  exp_addr;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
        int          ntx;
        logic [31:0] tx;
    } vec_t;

    vec_t vecs[9];

    int nvec = 0;
    int nmiss = 0;
    int cyc = 0;
    int wr_cnt, rd_cnt, err_cnt;
    int acc_edge, err_cyc;
    logic [3:0]  cap_waddr, cap_wsel, cap_raddr;
    logic [31:0] cap_wdata;
    logic [7:0]  tx_q[$];
    logic [31:0] last_wdata = 32'h0;
    logic rx_hs_s = 1'b0, tx_hs_s = 1'b0, tx_valid_s = 1'b0;
    logic prev_tv = 1'b0, prev_tr = 1'b0;
    logic [7:0] prev_td = 8'h00;
    logic rd_pend = 1'b0;
    logic [31:0] rd_model_val = 32'h0;
    int stall_en = 0;
    int stall_cnt = 0;

    function automatic vec_t mkv(input int nb, input logic [47:0] by, input int stall,
                                 input logic [31:0] rdv, input int ew, input int er,
                                 input logic [3:0] ea, input logic [3:0] es,
                                 input logic [31:0] ed, input int ntx, input logic [31:0] tx);
        vec_t v;
        v.nb = nb; v.by = by; v.stall = stall; v.rd_val = rdv;
        v.exp_wr = ew; v.exp_rd = er; v.exp_addr = ea; v.exp_sel = es;
        v.exp_wdata = ed; v.ntx = ntx; v.tx = tx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    always @(negedge clk) begin
        rx_hs_s    = rx_valid_i && rx_ready_o;
        tx_hs_s    = tx_valid_o && tx_ready_i;
        tx_valid_s = tx_valid_o;
        if (rx_hs_s) acc_edge = cyc + 1;
        if (wr_ena_o) begin
            wr_cnt++;
            cap_waddr = wr_addr_o;
            cap_wsel  = wr_byte_sel_o;
            cap_wdata = wr_data_o;
        end
        if (rd_ena_o) begin
            rd_cnt++;
            cap_raddr = rd_addr_o;
            rd_pend   = 1'b1;
        end
        if (tx_hs_s) tx_q.push_back(tx_data_o);
        if (err_timeout_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (wr_ena_o && rd_ena_o) begin
            nmiss++;
            $display("FAIL strobe_overlap: wr_ena_o and rd_ena_o both 1 at t=%0t", $time);
        end
        if (rx_ready_o && (tx_valid_o || wr_ena_o || rd_ena_o)) begin
            nmiss++;
            $display("FAIL rx_backpressure: rx_ready_o=1 required 0 at t=%0t", $time);
        end
        if (tx_valid_o && prev_tv && !prev_tr && tx_data_o !== prev_td) begin
            nmiss++;
            $display("FAIL tx_stable: got %02h required %02h at t=%0t", tx_data_o, prev_td, $time);
        end
        prev_tv = tx_valid_o;
        prev_tr = tx_ready_i;
        prev_td = tx_data_o;
    end

    initial begin : responder
        rd_data_i = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (rd_pend) begin
                rd_data_i = rd_model_val;
                rd_pend   = 1'b0;
            end else begin
                rd_data_i = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin : tx_sink
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tx_hs_s) stall_cnt = 0;
            else if (tx_valid_s) stall_cnt++;
            tx_ready_i = (stall_en == 0) || (stall_cnt >= 3);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (!rx_hs_s && n < 100);
        #1;
        rx_valid_i = 1'b0;
        if (!rx_hs_s) begin
            nmiss++;
            $display("FAIL rx_accept: byte %02h not accepted, required accept within 100 cycles", b);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < 300);
        chk("busy_after_packet", 32'(busy_o), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
        tx_q.delete();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        clear_mon();
        stall_cnt    = 0;
        stall_en     = v.stall;
        rd_model_val = v.rd_val;
        @(posedge clk);
        #1;
        for (int i = 0; i < v.nb; i++) send_byte(v.by[8*i +: 8]);
        wait_idle();
        chk($sformatf("v%0d_wr_cnt", idx), 32'(wr_cnt), 32'(v.exp_wr));
        chk($sformatf("v%0d_rd_cnt", idx), 32'(rd_cnt), 32'(v.exp_rd));
        if (v.exp_wr != 0) begin
            chk($sformatf("v%0d_wr_addr", idx), 32'(cap_waddr), 32'(v.exp_addr));
            chk($sformatf("v%0d_wr_sel", idx), 32'(cap_wsel), 32'(v.exp_sel));
            chk($sformatf("v%0d_wr_data", idx), cap_wdata, v.exp_wdata);
            last_wdata = v.exp_wdata;
        end
        if (v.exp_rd != 0) chk($sformatf("v%0d_rd_addr", idx), 32'(cap_raddr), 32'(v.exp_addr));
        chk($sformatf("v%0d_tx_count", idx), 32'(tx_q.size()), 32'(v.ntx));
        for (int i = 0; i < v.ntx; i++) begin
            if (i < tx_q.size()) chk($sformatf("v%0d_tx%0d", idx, i), 32'(tx_q[i]), 32'(v.tx[8*i +: 8]));
        end
        chk($sformatf("v%0d_err", idx), 32'(err_cnt), 32'h0);
        chk($sformatf("v%0d_wr_data_hold", idx), wr_data_o, last_wdata);
        stall_en = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vecs[0] = mkv(6, 48'h12_34_56_78_F0_57, 0, 32'h0,          1, 0, 4'h0, 4'hF, 32'h1234_5678, 1, 32'h0000_004B);
        vecs[1] = mkv(2, 48'h00_00_00_00_04_52, 0, 32'hA5A5_0003,  0, 1, 4'h4, 4'h0, 32'h0,         4, 32'hA5A5_0003);
        vecs[2] = mkv(2, 48'h00_00_00_00_04_52, 1, 32'hA5A5_0003,  0, 1, 4'h4, 4'h0, 32'h0,         4, 32'hA5A5_0003);
        vecs[3] = mkv(1, 48'h00_00_00_00_00_00, 0, 32'h0,          0, 0, 4'h0, 4'h0, 32'h0,         1, 32'h0000_003F);
        vecs[4] = mkv(6, 48'h44_33_22_11_5A_57, 0, 32'h0,          1, 0, 4'hA, 4'h5, 32'h4433_2211, 1, 32'h0000_004B);
        vecs[5] = mkv(2, 48'h00_00_00_00_1F_52, 0, 32'h8001_7FFE,  0, 1, 4'hF, 4'h0, 32'h0,         4, 32'h8001_7FFE);
        vecs[6] = mkv(1, 48'h00_00_00_00_00_FF, 0, 32'h0,          0, 0, 4'h0, 4'h0, 32'h0,         1, 32'h0000_003F);
        vecs[7] = mkv(6, 48'hCA_FE_D0_0D_C7_57, 0, 32'h0,          1, 0, 4'h7, 4'hC, 32'hCAFE_D00D, 1, 32'h0000_004B);
        vecs[8] = mkv(2, 48'h00_00_00_00_00_52, 0, 32'h0BAD_F00D,  0, 1, 4'h0, 4'h0, 32'h0,         4, 32'h0BAD_F00D);

        reset_i    = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready_o), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'h0);
        chk("rst_strobes", {30'h0, wr_ena_o, rd_ena_o}, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_err", 32'(err_timeout_o), 32'h0);
        chk("rst_wr_data", wr_data_o, 32'h0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", 32'(rx_ready_o), 32'h1);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // timeout: header + one data byte, then the source goes quiet
        clear_mon();
        @(posedge clk);
        #1;
        send_byte(8'h57);
        send_byte(8'h31);
        send_byte(8'hAA);
        begin
            int n = 0;
            while (err_cnt == 0 && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (4) @(negedge clk);
        chk("to_err_pulses", 32'(err_cnt), 32'h1);
        chk("to_err_delay", 32'(err_cyc - acc_edge), 32'd8);
        chk("to_no_write", 32'(wr_cnt), 32'h0);
        chk("to_no_tx", 32'(tx_q.size()), 32'h0);
        chk("to_idle", 32'(busy_o), 32'h0);
        run_vec(8, vecs[8]);

        // byte arriving on the limit cycle wins over the timeout
        clear_mon();
        @(posedge clk);
        #1;
        send_byte(8'h57);
        send_byte(8'h31);
        repeat (7) @(posedge clk);
        #1;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_idle();
        chk("bw_err", 32'(err_cnt), 32'h0);
        chk("bw_wr_cnt", 32'(wr_cnt), 32'h1);
        chk("bw_wr_addr", 32'(cap_waddr), 32'h1);
        chk("bw_wr_sel", 32'(cap_wsel), 32'h3);
        chk("bw_wr_data", cap_wdata, 32'h0403_0201);
        chk("bw_tx_count", 32'(tx_q.size()), 32'h1);
        if (tx_q.size() > 0) chk("bw_tx0", 32'(tx_q[0]), 32'h4B);
        last_wdata = 32'h0403_0201;

        // reset during the third write data byte
        clear_mon();
        send_byte(8'h57);
        send_byte(8'hF0);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_data_i  = 8'h33;
        rx_valid_i = 1'b1;
        reset_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_rx_ready", 32'(rx_ready_o), 32'h0);
        chk("mr_tx", {23'h0, tx_valid_o, tx_data_o}, 32'h0);
        chk("mr_strobes", {30'h0, wr_ena_o, rd_ena_o}, 32'h0);
        chk("mr_busy_err", {30'h0, busy_o, err_timeout_o}, 32'h0);
        chk("mr_wr_bus", {20'h0, wr_addr_o, wr_byte_sel_o, rd_addr_o}, 32'h0);
        chk("mr_wr_data", wr_data_o, 32'h0);
        @(posedge clk);
        #1;
        reset_i    = 1'b0;
        rx_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_no_write", 32'(wr_cnt), 32'h0);
        chk("mr_no_tx", 32'(tx_q.size()), 32'h0);
        last_wdata = 32'h0;
        run_vec(7, vecs[7]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
